// File: rtl/done_period_meter.sv
// done_period_meter
//   Measures the number of clk cycles between consecutive rising edges of
//   done_in, which comes from an upstream counter. Each measurement goes out
//   through a one-entry valid/ready output register. A measurement that
//   arrives while that register is still full is dropped, and a sticky
//   overrun flag is set.
//
// Parameters
//   PW  width of the period counter and of the period output
//   NW  width of the accepted-measurement counter
//
// Ports
//   clk           sole clock, rising edge
//   a_rst         asynchronous reset, active-high
//   clear         synchronous clear, active-high
//   done_in       done from the upstream counter, synchronous to clk
//   period        cycle count between two done_in rising edges
//   period_sat    1 = the period counter saturated during this measurement
//   period_valid  period/period_sat hold a pending measurement
//   period_ready  consumer accepts when period_valid && period_ready
//   overrun       sticky; a measurement was dropped because the output was full
//   num_periods   count of measurements loaded into the output register
//
// Every output is a register, so no input reaches an output combinationally.
module done_period_meter #(
  parameter int PW = 16,
  parameter int NW = 8
) (
  input  logic          clk,
  input  logic          a_rst,
  input  logic          clear,
  input  logic          done_in,
  output logic [PW-1:0] period,
  output logic          period_sat,
  output logic          period_valid,
  input  logic          period_ready,
  output logic          overrun,
  output logic [NW-1:0] num_periods
);

  typedef enum logic {
    IDLE,
    MEASURE
  } state_t;

  localparam logic [PW-1:0] CNT_MAX = '1;

  state_t        state;
  logic [PW-1:0] cnt;
  logic          sat_q;
  logic          done_q;
  logic          rise;
  logic          accept;
  logic          can_load;

  // done_q resets to 0, so done_in already high after reset counts as a rise.
  assign rise     = done_in && !done_q;
  assign accept   = period_valid && period_ready;
  // The output slot is free if it is empty or is being emptied this cycle.
  assign can_load = !period_valid || period_ready;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side below reads the value from before this clock edge.
  always_ff @(posedge clk or posedge a_rst) begin
    if (a_rst) begin
      state        <= IDLE;
      cnt          <= '0;
      sat_q        <= 1'b0;
      done_q       <= 1'b0;
      period       <= '0;
      period_sat   <= 1'b0;
      period_valid <= 1'b0;
      overrun      <= 1'b0;
      num_periods  <= '0;
    end else begin
      // The edge detector keeps sampling during clear, so a level held
      // across clear does not produce a second rise.
      done_q <= done_in;

      if (clear) begin
        state        <= IDLE;
        cnt          <= '0;
        sat_q        <= 1'b0;
        period_valid <= 1'b0;
        overrun      <= 1'b0;
        num_periods  <= '0;
      end else begin
        // An acceptance empties the slot. A load in this same cycle
        // (below) assigns period_valid later and overrides this.
        if (accept) begin
          period_valid <= 1'b0;
        end

        case (state)
          IDLE: begin
            if (rise) begin
              state <= MEASURE;
              cnt   <= {{(PW-1){1'b0}}, 1'b1};
              sat_q <= 1'b0;
            end
          end

          MEASURE: begin
            if (rise) begin
              if (can_load) begin
                period       <= cnt;
                period_sat   <= sat_q;
                period_valid <= 1'b1;
                num_periods  <= num_periods + 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              // The rise cycle is cycle 0 of the next measurement, so the
              // counter restarts at 1.
              cnt   <= {{(PW-1){1'b0}}, 1'b1};
              sat_q <= 1'b0;
            end else if (cnt != CNT_MAX) begin
              cnt <= cnt + 1'b1;
              if (cnt == CNT_MAX - 1'b1) begin
                sat_q <= 1'b1;
              end
            end
          end

          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_done_period_meter.sv
// Testbench for done_period_meter.
// Stimulus pushes each expected measurement into a queue at the moment it
// issues the rise that produces that measurement. A monitor runs on the
// falling edge. Whenever the DUT will hand over an output at the next rising
// edge, the monitor pops the queue and compares. A second instance, built
// with PW=4, exercises saturation.
module tb_done_period_meter;

  typedef struct packed {
    logic [15:0] p;
    logic        s;
  } exp_t;

  logic        clk = 1'b0;
  logic        a_rst;
  logic        clear;
  logic        done_in;
  logic        period_ready;
  logic [15:0] period;
  logic        period_sat;
  logic        period_valid;
  logic        overrun;
  logic [7:0]  num_periods;

  logic        done4;
  logic        ready4;
  logic [3:0]  period4;
  logic        sat4;
  logic        valid4;
  logic        overrun4;
  logic [7:0]  num4;

  exp_t exp_q[$];
  exp_t exp4_q[$];
  exp_t mon_e;
  exp_t mon4_e;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  done_period_meter #(.PW(16), .NW(8)) dut (
    .clk          (clk),
    .a_rst        (a_rst),
    .clear        (clear),
    .done_in      (done_in),
    .period       (period),
    .period_sat   (period_sat),
    .period_valid (period_valid),
    .period_ready (period_ready),
    .overrun      (overrun),
    .num_periods  (num_periods)
  );

  done_period_meter #(.PW(4), .NW(8)) dut4 (
    .clk          (clk),
    .a_rst        (a_rst),
    .clear        (clear),
    .done_in      (done4),
    .period       (period4),
    .period_sat   (sat4),
    .period_valid (valid4),
    .period_ready (ready4),
    .overrun      (overrun4),
    .num_periods  (num4)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitors: valid && ready at the falling edge means a handover at the next rising edge.
  always @(negedge clk) begin
    if (!a_rst && period_valid && period_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output: got period %0d, no measurement expected", period);
      end else begin
        mon_e = exp_q.pop_front();
        check("period", {16'd0, period}, {16'd0, mon_e.p});
        check("period_sat", {31'd0, period_sat}, {31'd0, mon_e.s});
      end
    end
  end

  always @(negedge clk) begin
    if (!a_rst && valid4 && ready4) begin
      if (exp4_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output4: got period %0d, no measurement expected", period4);
      end else begin
        mon4_e = exp4_q.pop_front();
        check("period4", {28'd0, period4}, {16'd0, mon4_e.p});
        check("period_sat4", {31'd0, sat4}, {31'd0, mon4_e.s});
      end
    end
  end

  // Inputs change 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input logic d);
    done_in = d;
    step();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0);
  endtask

  task automatic cyc4(input logic d);
    done4 = d;
    step();
  endtask

  task automatic idle4(input int n);
    for (int i = 0; i < n; i++) cyc4(1'b0);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    cyc(1'b0);
    clear = 1'b0;
  endtask

  task automatic push(input int p, input logic s);
    exp_t e;
    e.p = p[15:0];
    e.s = s;
    exp_q.push_back(e);
  endtask

  task automatic push4(input int p, input logic s);
    exp_t e;
    e.p = p[15:0];
    e.s = s;
    exp4_q.push_back(e);
  endtask

  initial begin
    a_rst        = 1'b1;
    clear        = 1'b0;
    done_in      = 1'b0;
    period_ready = 1'b0;
    done4        = 1'b0;
    ready4       = 1'b0;
    step();
    step();
    check("rst_period", {16'd0, period}, 0);
    check("rst_valid", {31'd0, period_valid}, 0);
    check("rst_sat", {31'd0, period_sat}, 0);
    check("rst_overrun", {31'd0, overrun}, 0);
    check("rst_num", {24'd0, num_periods}, 0);
    a_rst = 1'b0;

    // 1: rises 10 and 15 cycles apart, consumer always ready.
    period_ready = 1'b1;
    idle(3);
    cyc(1'b1);
    idle(9);
    push(10, 1'b0);
    cyc(1'b1);
    check("t1_valid_latency", {31'd0, period_valid}, 1);
    check("t1_num_first", {24'd0, num_periods}, 1);
    idle(14);
    push(15, 1'b0);
    cyc(1'b1);
    idle(3);
    check("t1_num", {24'd0, num_periods}, 2);
    check("t1_overrun", {31'd0, overrun}, 0);
    check("t1_valid_drained", {31'd0, period_valid}, 0);
    check("t1_queue", exp_q.size(), 0);

    // 2: consumer never ready, so the second measurement is dropped.
    period_ready = 1'b0;
    do_clear();
    check("t2_num_cleared", {24'd0, num_periods}, 0);
    cyc(1'b1);
    idle(9);
    push(10, 1'b0);
    cyc(1'b1);
    check("t2_overrun_before", {31'd0, overrun}, 0);
    idle(14);
    cyc(1'b1);
    check("t2_overrun_after", {31'd0, overrun}, 1);
    idle(2);
    check("t2_num", {24'd0, num_periods}, 1);
    check("t2_valid_held", {31'd0, period_valid}, 1);
    check("t2_period_held", {16'd0, period}, 10);
    period_ready = 1'b1;
    step();
    period_ready = 1'b0;
    check("t2_valid_after_accept", {31'd0, period_valid}, 0);
    check("t2_queue", exp_q.size(), 0);

    // 3: ready arrives in the same cycle as the rise.
    do_clear();
    cyc(1'b1);
    idle(9);
    push(10, 1'b0);
    cyc(1'b1);
    idle(14);
    push(15, 1'b0);
    period_ready = 1'b1;
    cyc(1'b1);
    period_ready = 1'b0;
    check("t3_valid_stays", {31'd0, period_valid}, 1);
    check("t3_period", {16'd0, period}, 15);
    check("t3_overrun", {31'd0, overrun}, 0);
    check("t3_num", {24'd0, num_periods}, 2);
    period_ready = 1'b1;
    step();
    period_ready = 1'b0;
    check("t3_queue", exp_q.size(), 0);

    // 4: PW=4 instance saturates on a 20-cycle period.
    ready4 = 1'b1;
    cyc4(1'b1);
    idle4(19);
    push4(15, 1'b1);
    cyc4(1'b1);
    idle4(4);
    push4(5, 1'b0);
    cyc4(1'b1);
    idle4(3);
    check("t4_num", {24'd0, num4}, 2);
    check("t4_overrun", {31'd0, overrun4}, 0);
    check("t4_queue", exp4_q.size(), 0);
    ready4 = 1'b0;

    // 5: asynchronous reset between clock edges while a result is pending.
    do_clear();
    cyc(1'b1);
    idle(9);
    cyc(1'b1);
    idle(3);
    check("t5_valid_pre", {31'd0, period_valid}, 1);
    #3;
    a_rst = 1'b1;
    #1;
    check("t5_async_period", {16'd0, period}, 0);
    check("t5_async_valid", {31'd0, period_valid}, 0);
    check("t5_async_num", {24'd0, num_periods}, 0);
    check("t5_async_overrun", {31'd0, overrun}, 0);
    done_in = 1'b1;
    step();
    step();
    a_rst = 1'b0;
    period_ready = 1'b1;
    step();
    idle(6);
    push(7, 1'b0);
    cyc(1'b1);
    idle(3);
    check("t5_num", {24'd0, num_periods}, 1);
    check("t5_queue", exp_q.size(), 0);

    // 6: clear with a pending result and a rise in the same cycle.
    period_ready = 1'b0;
    do_clear();
    cyc(1'b1);
    idle(9);
    cyc(1'b1);
    idle(4);
    cyc(1'b1);
    idle(2);
    check("t6_valid_pre", {31'd0, period_valid}, 1);
    check("t6_overrun_pre", {31'd0, overrun}, 1);
    clear = 1'b1;
    cyc(1'b1);
    clear = 1'b0;
    check("t6_valid", {31'd0, period_valid}, 0);
    check("t6_overrun", {31'd0, overrun}, 0);
    check("t6_num", {24'd0, num_periods}, 0);
    period_ready = 1'b1;
    idle(2);
    cyc(1'b1);
    idle(6);
    push(7, 1'b0);
    cyc(1'b1);
    idle(3);
    check("t6_num_after", {24'd0, num_periods}, 1);
    check("t6_queue", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
